// File: rtl/dvi_tmds_encoder.sv
// Single-lane DVI TMDS 8b/10b encoder: three register stages, pixel data or control token in, 10-bit symbol out.
// Latency 3 clk, one symbol per clk; no backpressure (the serialiser consumes every symbol).
module dvi_tmds_encoder #(
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       de,
    input  logic [1:0] c,
    input  logic [7:0] din,
    output logic [9:0] dout
);

    localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    // Stage 1: unused inputs are zeroed so X never enters the pipeline.
    logic       s1_vld, s1_de;
    logic [1:0] s1_c;
    logic [7:0] s1_din;
    logic [3:0] s1_n1d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_de  <= 1'b0;
            s1_c   <= 2'b00;
            s1_din <= 8'h00;
            s1_n1d <= 4'd0;
        end else begin
            s1_vld <= 1'b1;
            s1_de  <= de;
            s1_c   <= de ? 2'b00 : c;
            s1_din <= de ? din : 8'h00;
            s1_n1d <= de ? popcount8(din) : 4'd0;
        end
    end

    // Stage 2: transition minimisation.
    logic       use_xnor;
    logic [8:0] q_m;

    always_comb begin
        use_xnor = (s1_n1d > 4'd4) || ((s1_n1d == 4'd4) && !s1_din[0]);
        q_m      = '0;
        q_m[0]   = s1_din[0];
        for (int i = 1; i < 8; i++)
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ s1_din[i]) : (q_m[i-1] ^ s1_din[i]);
        q_m[8]   = !use_xnor;
    end

    logic       s2_vld, s2_de;
    logic [1:0] s2_c;
    logic [8:0] s2_qm;
    logic [3:0] s2_n1q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_de  <= 1'b0;
            s2_c   <= 2'b00;
            s2_qm  <= 9'h000;
            s2_n1q <= 4'd0;
        end else begin
            s2_vld <= s1_vld;
            s2_de  <= s1_de;
            s2_c   <= s1_c;
            s2_qm  <= q_m;
            s2_n1q <= popcount8(q_m[7:0]);
        end
    end

    // Stage 3: DC balance against the running disparity.
    logic signed [CNT_W-1:0] cnt, cnt_nxt, n1s, n0s;
    logic [9:0]              dout_nxt;
    logic                    cnt_pos, cnt_neg, qm8;

    always_comb begin
        n1s      = CNT_W'(s2_n1q);
        n0s      = CNT_W'(4'd8 - s2_n1q);
        cnt_neg  = cnt[CNT_W-1];
        cnt_pos  = !cnt[CNT_W-1] && (cnt != '0);
        qm8      = s2_qm[8];
        dout_nxt = 10'h000;
        cnt_nxt  = '0;
        if (s2_vld) begin
            if (!s2_de) begin
                case (s2_c)
                    2'b00:   dout_nxt = 10'b1101010100;
                    2'b01:   dout_nxt = 10'b0010101011;
                    2'b10:   dout_nxt = 10'b0101010100;
                    default: dout_nxt = 10'b1010101011;
                endcase
            end else if ((cnt == '0) || (s2_n1q == 4'd4)) begin
                dout_nxt = {~qm8, qm8, qm8 ? s2_qm[7:0] : ~s2_qm[7:0]};
                cnt_nxt  = qm8 ? (cnt + n1s - n0s) : (cnt + n0s - n1s);
            end else if ((cnt_pos && (s2_n1q > 4'd4)) || (cnt_neg && (s2_n1q < 4'd4))) begin
                dout_nxt = {1'b1, qm8, ~s2_qm[7:0]};
                cnt_nxt  = qm8 ? (cnt + TWO + n0s - n1s) : (cnt + n0s - n1s);
            end else begin
                dout_nxt = {1'b0, qm8, s2_qm[7:0]};
                cnt_nxt  = qm8 ? (cnt + n1s - n0s) : (cnt + n1s - n0s - TWO);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= 10'h000;
            cnt  <= '0;
        end else begin
            dout <= dout_nxt;
            cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Bench for dvi_tmds_encoder: constant vector table plus random traffic against a behavioural encoder, with decode-back.
module tb_dvi_tmds_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       de  = 1'b0;
    logic [1:0] c   = 2'b00;
    logic [7:0] din = 8'h00;
    logic [9:0] dout;

    dvi_tmds_encoder #(.CNT_W(5)) dut (
        .clk  (clk),
        .rst  (rst),
        .de   (de),
        .c    (c),
        .din  (din),
        .dout (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       de;
        logic [7:0] din;
        logic [9:0] exp;
    } sb_t;

    typedef struct {
        logic       de;
        logic [1:0] c;
        logic [7:0] din;
        logic [9:0] exp;
    } vec_t;

    sb_t  sbq[$];
    vec_t vecs[21];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   m_cnt = 0;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] t, o;
        t    = s[9] ? ~s[7:0] : s[7:0];
        o[0] = t[0];
        for (int i = 1; i < 8; i++)
            o[i] = s[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        return o;
    endfunction

    task automatic model(input logic d, input logic [1:0] cc, input logic [7:0] dd, output logic [9:0] o);
        int         n1d, n1q, n0q;
        logic       xn;
        logic [8:0] qm;
        if (!d) begin
            case (cc)
                2'b00:   o = 10'h354;
                2'b01:   o = 10'h0AB;
                2'b10:   o = 10'h154;
                default: o = 10'h2AB;
            endcase
            m_cnt = 0;
        end else begin
            n1d   = $countones(dd);
            xn    = (n1d > 4) || (n1d == 4 && dd[0] == 1'b0);
            qm    = '0;
            qm[0] = dd[0];
            for (int i = 1; i < 8; i++)
                qm[i] = xn ? ~(qm[i-1] ^ dd[i]) : (qm[i-1] ^ dd[i]);
            qm[8] = !xn;
            n1q   = $countones(qm[7:0]);
            n0q   = 8 - n1q;
            if (m_cnt == 0 || n1q == n0q) begin
                o     = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                m_cnt = m_cnt + (qm[8] ? (n1q - n0q) : (n0q - n1q));
            end else if ((m_cnt > 0 && n1q > n0q) || (m_cnt < 0 && n0q > n1q)) begin
                o     = {1'b1, qm[8], ~qm[7:0]};
                m_cnt = m_cnt + (qm[8] ? 2 : 0) + n0q - n1q;
            end else begin
                o     = {1'b0, qm[8], qm[7:0]};
                m_cnt = m_cnt + n1q - n0q - (qm[8] ? 0 : 2);
            end
        end
    endtask

    // One clock: compare what is due, then drive the next input and queue its expectation.
    task automatic step(input logic d, input logic [1:0] cc, input logic [7:0] dd,
                        input logic [9:0] e, input bit use_model, input bit zchk, input bit push);
        logic [9:0] m;
        sb_t        s;
        @(posedge clk);
        #1;
        cyc++;
        if (zchk) check("flush_zero", dout, 10'h000);
        if (sbq.size() > 0 && sbq[0].cyc + 3 == cyc) begin
            s = sbq.pop_front();
            check("symbol", dout, s.exp);
            if (s.de) check("decode", {2'b00, decode(dout)}, {2'b00, s.din});
        end
        if (push) begin
            de  = d;
            c   = d ? 2'($urandom) : cc;
            din = d ? dd : 8'($urandom);
            model(d, cc, dd, m);
            s.cyc = cyc;
            s.de  = d;
            s.din = dd;
            s.exp = use_model ? m : e;
            sbq.push_back(s);
        end else begin
            de  = 1'b0;
            c   = 2'b00;
            din = 8'($urandom);
        end
    endtask

    task automatic release_reset();
        sb_t s;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        check("reset_hold", dout, 10'h000);
        de    = 1'b0;
        c     = 2'b00;
        din   = 8'($urandom);
        m_cnt = 0;
        s.cyc = cyc;
        s.de  = 1'b0;
        s.din = 8'h00;
        s.exp = 10'h354;
        sbq.push_back(s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int     len;
        logic   dd_de;

        vecs[0]  = '{1'b0, 2'b00, 8'h00, 10'h354};
        vecs[1]  = '{1'b0, 2'b01, 8'h00, 10'h0AB};
        vecs[2]  = '{1'b0, 2'b10, 8'h00, 10'h154};
        vecs[3]  = '{1'b0, 2'b11, 8'h00, 10'h2AB};
        vecs[4]  = '{1'b1, 2'b00, 8'h00, 10'h100};
        vecs[5]  = '{1'b1, 2'b00, 8'h00, 10'h3FF};
        vecs[6]  = '{1'b1, 2'b00, 8'h00, 10'h100};
        vecs[7]  = '{1'b1, 2'b00, 8'h00, 10'h3FF};
        vecs[8]  = '{1'b0, 2'b00, 8'h00, 10'h354};
        vecs[9]  = '{1'b1, 2'b00, 8'hFF, 10'h200};
        vecs[10] = '{1'b1, 2'b00, 8'hFF, 10'h0FF};
        vecs[11] = '{1'b1, 2'b00, 8'h00, 10'h3FF};
        vecs[12] = '{1'b1, 2'b00, 8'h00, 10'h100};
        vecs[13] = '{1'b1, 2'b00, 8'h00, 10'h100};
        vecs[14] = '{1'b0, 2'b00, 8'h00, 10'h354};
        vecs[15] = '{1'b1, 2'b00, 8'h00, 10'h100};
        vecs[16] = '{1'b1, 2'b00, 8'h01, 10'h1FF};
        vecs[17] = '{1'b1, 2'b00, 8'h0F, 10'h105};
        vecs[18] = '{1'b1, 2'b00, 8'hF0, 10'h0FA};
        vecs[19] = '{1'b0, 2'b11, 8'h00, 10'h2AB};
        vecs[20] = '{1'b1, 2'b00, 8'h00, 10'h100};

        // Power-on reset with random inputs applied.
        de  = 1'b1;
        c   = 2'($urandom);
        din = 8'($urandom);
        #2 rst = 1'b1;
        #1 check("reset_async", dout, 10'h000);
        repeat (3) @(posedge clk);
        #1 check("reset_clocked", dout, 10'h000);
        release_reset();

        for (int i = 0; i < 21; i++)
            step(vecs[i].de, vecs[i].c, vecs[i].din, vecs[i].exp, 1'b0, i < 2, 1'b1);

        // Random traffic with de runs of 1..200 and short blanking gaps.
        step(1'b0, 2'b00, 8'h00, 10'h000, 1'b1, 1'b0, 1'b1);
        dd_de = 1'b1;
        while (cyc < 3000) begin
            len = dd_de ? $urandom_range(1, 200) : $urandom_range(1, 12);
            for (int k = 0; k < len; k++)
                step(dd_de, 2'($urandom), 8'($urandom), 10'h000, 1'b1, 1'b0, 1'b1);
            dd_de = !dd_de;
        end

        // Reset in the middle of a data run.
        step(1'b1, 2'b00, 8'hA5, 10'h000, 1'b1, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1 check("reset_mid_async", dout, 10'h000);
        sbq.delete();
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1 check("reset_mid_clocked", dout, 10'h000);
        release_reset();
        step(1'b1, 2'b00, 8'h00, 10'h100, 1'b0, 1'b1, 1'b1);
        step(1'b1, 2'b00, 8'h00, 10'h3FF, 1'b0, 1'b1, 1'b1);
        step(1'b0, 2'b01, 8'h00, 10'h0AB, 1'b0, 1'b0, 1'b1);
        repeat (4) step(1'b0, 2'b00, 8'h00, 10'h000, 1'b0, 1'b0, 1'b0);

        if (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain left %0d want 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
